// File: rtl/text_render_pipeline.sv
// rtl/text_render_pipeline.sv - five-stage pipelined text overlay: cell addressing, glyph fetch, cursor, delayed syncs
// Blinking cursor is built only when TEXT_RENDER_CURSOR_BLINK_EN is defined; otherwise the cursor is steady.
module text_render_pipeline #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_WIDTH   = 8,
    parameter int CHAR_HEIGHT  = 16,
    parameter int OFFSET_LEFT  = 0,
    parameter int OFFSET_TOP   = 0,
    parameter int CODE_W       = 7,
    parameter int NUM_FONTS    = 2,
    parameter int BLINK_FRAMES = 30,
    localparam int FW = (NUM_FONTS > 1) ? $clog2(NUM_FONTS) : 1,
    localparam int XW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int RW = $clog2(CHAR_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [9:0]            pixel_x,
    input  logic [9:0]            pixel_y,
    input  logic                  video_on,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  frame_tick,
    input  logic [FW-1:0]         font_sel,
    input  logic                  cursor_en,
    input  logic [XW-1:0]         cursor_x,
    input  logic [YW-1:0]         cursor_y,
    output logic [XW-1:0]         read_x,
    output logic [YW-1:0]         read_y,
    input  logic [CODE_W-1:0]     char_at_pos,
    output logic [CODE_W-1:0]     glyph_code,
    output logic [FW-1:0]         glyph_font,
    output logic [RW-1:0]         glyph_row,
    input  logic [CHAR_WIDTH-1:0] glyph_line,
    output logic                  text_bit_on,
    output logic                  video_on_out,
    output logic                  hsync_out,
    output logic                  vsync_out
);
    localparam int              CWL      = $clog2(CHAR_WIDTH);
    localparam logic [9:0]      OFF_L    = 10'(OFFSET_LEFT);
    localparam logic [9:0]      OFF_T    = 10'(OFFSET_TOP);
    localparam logic [9:0]      COLS_V   = 10'(COLS);
    localparam logic [9:0]      ROWS_V   = 10'(ROWS);
    localparam logic [CWL-1:0]  COL_LAST = CWL'(CHAR_WIDTH - 1);

    typedef struct packed {
        logic           vld;
        logic           vid;
        logic           hs;
        logic           vs;
        logic           area;
        logic           inv;
        logic [CWL-1:0] col;
        logic [RW-1:0]  row;
        logic [FW-1:0]  font;
    } side_t;

    logic [9:0]        ax;
    logic [9:0]        ay;
    logic [9:0]        cell_x;
    logic [9:0]        cell_y;
    logic              in_area;
    logic              cursor_hit;
    logic              blink_phase;
    logic [XW-1:0]     read_x_d;
    logic [YW-1:0]     read_y_d;
    side_t             side_d;
    side_t             side_q [4];
    logic              pix_bit;

    logic [XW-1:0]     read_x_q;
    logic [YW-1:0]     read_y_q;
    logic [CODE_W-1:0] glyph_code_q;
    logic [FW-1:0]     glyph_font_q;
    logic [RW-1:0]     glyph_row_q;
    logic              text_bit_q;
    logic              video_on_q;
    logic              hsync_q;
    logic              vsync_q;

`ifdef TEXT_RENDER_CURSOR_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [BW-1:0] blink_cnt_q;
    logic          blink_phase_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
        end else if (frame_tick) begin
            if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_q   <= '0;
                blink_phase_q <= ~blink_phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + 1'b1;
            end
        end
    end

    assign blink_phase = blink_phase_q;
`else
    logic unused_frame_tick;

    assign unused_frame_tick = frame_tick & (BLINK_FRAMES > 0);
    assign blink_phase       = 1'b1;
`endif

    // Pixels left of / above the offset wrap to large values and fail the bound checks below.
    always_comb begin
        ax       = pixel_x - OFF_L;
        ay       = pixel_y - OFF_T;
        cell_x   = ax >> CWL;
        cell_y   = ay >> RW;
        in_area  = (pixel_x >= OFF_L) && (pixel_y >= OFF_T) &&
                   (cell_x < COLS_V) && (cell_y < ROWS_V);
        // cell is bounded by in_area, so an out-of-range cursor can never match
        cursor_hit = cursor_en && in_area &&
                     (cell_x == 10'(cursor_x)) && (cell_y == 10'(cursor_y));
        read_x_d = in_area ? cell_x[XW-1:0] : '0;
        read_y_d = in_area ? cell_y[YW-1:0] : '0;

        side_d      = '0;
        side_d.vld  = 1'b1;
        side_d.vid  = video_on;
        side_d.hs   = hsync_in;
        side_d.vs   = vsync_in;
        side_d.area = in_area;
        side_d.inv  = cursor_hit && blink_phase;
        side_d.col  = ax[CWL-1:0];
        side_d.row  = ay[RW-1:0];
        side_d.font = font_sel;
    end

    assign pix_bit = glyph_line[COL_LAST - side_q[3].col];

    always_ff @(posedge clk) begin
        if (reset) begin
            read_x_q     <= '0;
            read_y_q     <= '0;
            glyph_code_q <= '0;
            glyph_font_q <= '0;
            glyph_row_q  <= '0;
            text_bit_q   <= 1'b0;
            video_on_q   <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                side_q[i] <= '0;
            end
        end else begin
            read_x_q  <= read_x_d;
            read_y_q  <= read_y_d;
            side_q[0] <= side_d;
            for (int i = 1; i < 4; i++) begin
                side_q[i] <= side_q[i-1];
            end
            // vld keeps stale buffer data from leaking out while the pipe refills after reset
            glyph_code_q <= side_q[1].vld ? char_at_pos : '0;
            glyph_font_q <= side_q[1].font;
            glyph_row_q  <= side_q[1].row;
            text_bit_q   <= side_q[3].vid && side_q[3].area && (pix_bit ^ side_q[3].inv);
            video_on_q   <= side_q[3].vid;
            hsync_q      <= side_q[3].hs;
            vsync_q      <= side_q[3].vs;
        end
    end

    assign read_x       = read_x_q;
    assign read_y       = read_y_q;
    assign glyph_code   = glyph_code_q;
    assign glyph_font   = glyph_font_q;
    assign glyph_row    = glyph_row_q;
    assign text_bit_on  = text_bit_q;
    assign video_on_out = video_on_q;
    assign hsync_out    = hsync_q;
    assign vsync_out    = vsync_q;

endmodule

// File: tb/tb_text_render_pipeline.sv
// tb/tb_text_render_pipeline.sv - bench for text_render_pipeline: default instance and offset/narrow instance
// Expected pixels come from a cycle-indexed reference model of cell arithmetic, memories and cursor blink.
module tb_text_render_pipeline;
    localparam int DEPTH = 8192;
    localparam int BLINK = 2;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [9:0] px, py;
    logic       vid, hs, vs, ft, fsel, cen;
    int         cur_x_i, cur_y_i;
    logic [6:0] cxa;
    logic [5:0] cxb;
    logic [4:0] cy;
    assign cxa = 7'(cur_x_i);
    assign cxb = 6'(cur_x_i);
    assign cy  = 5'(cur_y_i);

    logic [6:0] a_rx, a_char, a_code;
    logic [4:0] a_ry;
    logic [0:0] a_font;
    logic [3:0] a_row;
    logic [7:0] a_gl;
    logic       a_bit, a_vid, a_hs, a_vs;
    logic [5:0] b_rx;
    logic [6:0] b_char, b_code;
    logic [4:0] b_ry;
    logic [0:0] b_font;
    logic [3:0] b_row;
    logic [7:0] b_gl;
    logic       b_bit, b_vid, b_hs, b_vs;

    text_render_pipeline #(.BLINK_FRAMES(BLINK)) u_a (
        .clk(clk), .reset(rst), .pixel_x(px), .pixel_y(py), .video_on(vid),
        .hsync_in(hs), .vsync_in(vs), .frame_tick(ft), .font_sel(fsel),
        .cursor_en(cen), .cursor_x(cxa), .cursor_y(cy), .read_x(a_rx), .read_y(a_ry),
        .char_at_pos(a_char), .glyph_code(a_code), .glyph_font(a_font), .glyph_row(a_row),
        .glyph_line(a_gl), .text_bit_on(a_bit), .video_on_out(a_vid), .hsync_out(a_hs),
        .vsync_out(a_vs));

    text_render_pipeline #(.OFFSET_LEFT(16), .COLS(40), .BLINK_FRAMES(BLINK)) u_b (
        .clk(clk), .reset(rst), .pixel_x(px), .pixel_y(py), .video_on(vid),
        .hsync_in(hs), .vsync_in(vs), .frame_tick(ft), .font_sel(fsel),
        .cursor_en(cen), .cursor_x(cxb), .cursor_y(cy), .read_x(b_rx), .read_y(b_ry),
        .char_at_pos(b_char), .glyph_code(b_code), .glyph_font(b_font), .glyph_row(b_row),
        .glyph_line(b_gl), .text_bit_on(b_bit), .video_on_out(b_vid), .hsync_out(b_hs),
        .vsync_out(b_vs));

    logic [6:0] text_mem [0:31][0:127];
    bit         gforce;
    logic [7:0] gval;

    function automatic logic [7:0] gfun(input int font, input int code, input int row);
        if (gforce) return gval;
        return 8'((code * 37 + row * 11 + font * 101) ^ 'h5A);
    endfunction

    always @(posedge clk) begin
        a_char <= text_mem[a_ry][a_rx];
        a_gl   <= gfun(int'(a_font), int'(a_code), int'(a_row));
        b_char <= text_mem[b_ry][b_rx];
        b_gl   <= gfun(int'(b_font), int'(b_code), int'(b_row));
    end

    typedef struct {
        int rx, ry, code, row, font;
        bit pix, vid, hs, vs;
    } rec_t;

    rec_t rec [2][DEPTH];
    int   offl  [2] = '{0, 16};
    int   ncols [2] = '{80, 40};
    int   cxmod [2] = '{128, 64};
    int   cyc, last_rst, ticks;
    int   checks, failures;

    task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic record();
        bit phase;
        phase = 1'b1;
`ifdef TEXT_RENDER_CURSOR_BLINK_EN
        phase = ((ticks / BLINK) % 2) == 0;
`endif
        for (int d = 0; d < 2; d++) begin
            int ax, ay, col;
            bit area, inv;
            logic [7:0] g;
            rec_t r;
            ax     = int'(px) - offl[d];
            ay     = int'(py);
            area   = (ax >= 0) && (ax / 8 < ncols[d]) && (ay / 16 < 30);
            r.rx   = area ? ax / 8 : 0;
            r.ry   = area ? ay / 16 : 0;
            r.code = int'(text_mem[r.ry][r.rx]);
            r.row  = ay % 16;
            r.font = int'(fsel);
            col    = area ? ax % 8 : 0;
            inv    = cen && area && phase && (r.rx == cur_x_i % cxmod[d]) && (r.ry == cur_y_i);
            g      = gfun(r.font, r.code, r.row);
            r.pix  = vid && area && (g[7 - col] ^ inv);
            r.vid  = vid;
            r.hs   = hs;
            r.vs   = vs;
            rec[d][cyc % DEPTH] = r;
        end
        if (rst) ticks = 0;
        else if (ft) ticks++;
    endtask

    function automatic rec_t pick(input int d, input int idx);
        rec_t z;
        if (idx > last_rst) return rec[d][idx % DEPTH];
        z.rx = 0; z.ry = 0; z.code = 0; z.row = 0; z.font = 0;
        z.pix = 0; z.vid = 0; z.hs = 0; z.vs = 0;
        return z;
    endfunction

    task automatic check_dut(input int d);
        rec_t r1, r3, r5;
        r1 = pick(d, cyc - 1);
        r3 = pick(d, cyc - 3);
        r5 = pick(d, cyc - 5);
        if (d == 0) begin
            expect_eq("a_read_x", 32'(a_rx), r1.rx);
            expect_eq("a_read_y", 32'(a_ry), r1.ry);
            expect_eq("a_glyph_code", 32'(a_code), r3.code);
            expect_eq("a_glyph_row", 32'(a_row), r3.row);
            expect_eq("a_glyph_font", 32'(a_font), r3.font);
            expect_eq("a_text_bit", 32'(a_bit), 32'(r5.pix));
            expect_eq("a_video_on_out", 32'(a_vid), 32'(r5.vid));
            expect_eq("a_hsync_out", 32'(a_hs), 32'(r5.hs));
            expect_eq("a_vsync_out", 32'(a_vs), 32'(r5.vs));
        end else begin
            expect_eq("b_read_x", 32'(b_rx), r1.rx);
            expect_eq("b_read_y", 32'(b_ry), r1.ry);
            expect_eq("b_glyph_code", 32'(b_code), r3.code);
            expect_eq("b_glyph_row", 32'(b_row), r3.row);
            expect_eq("b_glyph_font", 32'(b_font), r3.font);
            expect_eq("b_text_bit", 32'(b_bit), 32'(r5.pix));
            expect_eq("b_video_on_out", 32'(b_vid), 32'(r5.vid));
            expect_eq("b_hsync_out", 32'(b_hs), 32'(r5.hs));
            expect_eq("b_vsync_out", 32'(b_vs), 32'(r5.vs));
        end
    endtask

    task automatic hold(input int n);
        repeat (n) begin
            record();
            if (rst) last_rst = cyc;
            @(posedge clk);
            #1;
            cyc++;
            check_dut(0);
            check_dut(1);
        end
    endtask

    task automatic fill_text();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 128; c++)
                text_mem[r][c] = 7'($urandom);
    endtask

    initial begin
        int lit_a, lit_b, exp_after2;
        checks = 0; failures = 0;
        cyc = 0; last_rst = -1; ticks = 0;
        rst = 1; px = 0; py = 0; vid = 0; hs = 0; vs = 0; ft = 0; fsel = 0; cen = 0;
        cur_x_i = 0; cur_y_i = 0; gforce = 0; gval = 0;
        fill_text();

        hold(3);
        expect_eq("rst_a_read_x", 32'(a_rx), 0);
        expect_eq("rst_a_glyph_code", 32'(a_code), 0);
        expect_eq("rst_a_text_bit", 32'(a_bit), 0);
        expect_eq("rst_b_video_on_out", 32'(b_vid), 0);

        text_mem[0][0] = 7'h41; gforce = 1; gval = 8'h18;
        hold(1);
        rst = 0; vid = 1;
        hold(3);
        expect_eq("A_glyph_code", 32'(a_code), 32'h41);
        hold(2);
        expect_eq("A_x0_bit", 32'(a_bit), 0);
        px = 3;
        hold(6);
        expect_eq("A_x3_bit", 32'(a_bit), 1);

        rst = 1; gval = 8'hFF;
        hold(1);
        rst = 0;
        px = 10;
        hold(6);
        expect_eq("off_x10_read_x", 32'(b_rx), 0);
        expect_eq("off_x10_bit", 32'(b_bit), 0);
        px = 16;
        hold(6);
        expect_eq("off_x16_read_x", 32'(b_rx), 0);
        expect_eq("off_x16_bit", 32'(b_bit), 1);
        px = 639; py = 479;
        hold(6);
        expect_eq("corner_read_x", 32'(a_rx), 79);
        expect_eq("corner_read_y", 32'(a_ry), 29);
        expect_eq("corner_bit", 32'(a_bit), 1);
        expect_eq("narrow_corner_bit", 32'(b_bit), 0);

        rst = 1; gval = 8'h00;
        hold(1);
        rst = 0; cen = 1; cur_x_i = 2; cur_y_i = 1;
        lit_a = 0; lit_b = 0;
        for (int y = 0; y < 40; y++) begin
            for (int x = 0; x < 32; x++) begin
                px = 10'(x); py = 10'(y);
                hold(1);
                lit_a += int'(a_bit);
                lit_b += int'(b_bit);
            end
        end
        vid = 0;
        for (int i = 0; i < 5; i++) begin
            hold(1);
            lit_a += int'(a_bit);
            lit_b += int'(b_bit);
        end
        expect_eq("cursor_lit_count", lit_a, 128);
        expect_eq("narrow_cursor_lit_count", lit_b, 0);

        vid = 1; px = 16; py = 16;
        hold(6);
        expect_eq("cursor_visible", 32'(a_bit), 1);
`ifdef TEXT_RENDER_CURSOR_BLINK_EN
        exp_after2 = 0;
`else
        exp_after2 = 1;
`endif
        ft = 1; hold(1); ft = 0; hold(1); ft = 1; hold(1); ft = 0;
        hold(6);
        expect_eq("cursor_after_2_ticks", 32'(a_bit), exp_after2);
        ft = 1; hold(1); ft = 0; hold(1); ft = 1; hold(1); ft = 0;
        hold(6);
        expect_eq("cursor_after_4_ticks", 32'(a_bit), 1);

        hs = 1;
        hold(1);
        hs = 0;
        hold(3);
        expect_eq("hsync_n4", 32'(a_hs), 0);
        hold(1);
        expect_eq("hsync_n5", 32'(a_hs), 1);
        hold(1);
        expect_eq("hsync_n6", 32'(a_hs), 0);

        rst = 1; gforce = 0;
        fill_text();
        hold(1);
        rst = 0;
        for (int i = 0; i < 2000; i++) begin
            px   = 10'($urandom_range(0, 799));
            py   = 10'($urandom_range(0, 524));
            vid  = ($urandom_range(0, 3) != 0);
            hs   = 1'($urandom);
            vs   = 1'($urandom);
            ft   = ($urandom_range(0, 5) == 0);
            fsel = 1'($urandom);
            cen  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                cur_x_i = int'(px) / 8;
                cur_y_i = int'(py) / 16;
                if (cur_x_i > 127) cur_x_i = 127;
                if (cur_y_i > 31) cur_y_i = 31;
            end else begin
                cur_x_i = $urandom_range(0, 127);
                cur_y_i = $urandom_range(0, 31);
            end
            if (i == 1000) rst = 1;
            hold(1);
            if (i == 1000) begin
                rst = 0;
                expect_eq("midreset_a_bit", 32'(a_bit), 0);
                expect_eq("midreset_a_video_on_out", 32'(a_vid), 0);
                expect_eq("midreset_a_hsync_out", 32'(a_hs), 0);
                expect_eq("midreset_a_glyph_code", 32'(a_code), 0);
                expect_eq("midreset_b_read_x", 32'(b_rx), 0);
            end
        end
        vid = 0; hs = 0; vs = 0; ft = 0;
        hold(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
